// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
//   Shared definitions for the 8-bit processor sequencer:
//   - opcode values (OP_ADD .. OP_HALT)
//   - sequencer FSM state encoding
//   - instruction field bit positions
//   - is_alu_op(): true for the opcodes that go through EXEC and update flags
// -----------------------------------------------------------------------------
package proc_pkg;

    // Opcodes, instruction bits [15:12]. Anything not listed executes as NOP.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_LOAD = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Instruction field positions within the 16-bit word.
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int RSA_MSB = 5;
    localparam int RSA_LSB = 4;
    localparam int RSB_MSB = 1;
    localparam int RSB_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

endpackage

// File: rtl/proc_alu.sv
// -----------------------------------------------------------------------------
// proc_alu
//   Purely combinational ALU for the sequencer.
//   Ports:
//     op_i      opcode (only ADD/SUB/AND/OR/XOR produce a result; others give 0)
//     a_i, b_i  operands, DATA_W bits
//     result_o  result modulo 2**DATA_W
//     carry_o   ADD: carry-out; SUB: borrow (a_i < b_i unsigned); logic ops: 0
//     zero_o    result_o == 0
// -----------------------------------------------------------------------------
module proc_alu
    import proc_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o,
    output logic              zero_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // One extra bit on each side so the carry/borrow falls out as the MSB.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave it unassigned, which would otherwise infer a latch.
        result_o = '0;
        carry_o  = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/proc_seq_core.sv
// -----------------------------------------------------------------------------
// proc_seq_core
//   Multi-cycle fetch/decode/execute sequencer. Owns PC, IR, a 4-entry register
//   file, Z/C flags and the control FSM; fetches 16-bit words from a synchronous
//   program memory (data returns one cycle after the fetch strobe).
//   Ports:
//     clk, rst_n   clock (rising edge), asynchronous active-low reset
//     start        run from PC=0; honoured only in IDLE or HALTED
//     imem_addr    fetch address (current PC)
//     imem_rd      fetch strobe, high in FETCH
//     imem_data    instruction word, valid the cycle after imem_rd
//     dbg_addr     debug register select
//     dbg_data     combinational read of reg[dbg_addr]
//     busy         high in FETCH/DECODE/EXEC/WB
//     halted       high in HALTED
//     flag_z       zero flag
//     flag_c       carry (ADD) / borrow (SUB) flag
//     instr_done   one-cycle pulse when an instruction retires
// -----------------------------------------------------------------------------
module proc_seq_core
    import proc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PROG_AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PROG_AW-1:0] imem_addr,
    output logic               imem_rd,
    input  logic [15:0]        imem_data,
    input  logic [1:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data,
    output logic               busy,
    output logic               halted,
    output logic               flag_z,
    output logic               flag_c,
    output logic               instr_done
);

    state_e              state_q, state_d;
    logic [PROG_AW-1:0]  pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   rf_q [4];
    logic                z_q, c_q;
    logic [DATA_W-1:0]   alu_res_q;
    logic                alu_c_q, alu_z_q;
    // Low for the first edge after reset release so a start held across the
    // release is not taken.
    logic                armed_q;

    logic                rf_we;
    logic [DATA_W-1:0]   rf_wdata;
    logic                flag_we;
    logic                ex_we;

    logic [3:0]          dec_op;
    logic [3:0]          ir_op;
    logic [1:0]          ir_rd;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_c, alu_z;

    // Bits 11:10 of the instruction carry no field.
    logic                unused_ir_bits;
    assign unused_ir_bits = ^ir_q[11:10];

    // The opcode is decoded straight off the memory bus in DECODE; IR holds the
    // word for the EXEC/WB cycles that follow.
    assign dec_op = imem_data[OP_MSB:OP_LSB];
    assign ir_op  = ir_q[OP_MSB:OP_LSB];
    assign ir_rd  = ir_q[RD_MSB:RD_LSB];

    // Operands are read in EXEC, before any WB write, so rd may alias rs_a/rs_b.
    proc_alu #(.DATA_W(DATA_W)) u_alu (
        .op_i     (ir_op),
        .a_i      (rf_q[ir_q[RSA_MSB:RSA_LSB]]),
        .b_i      (rf_q[ir_q[RSB_MSB:RSB_LSB]]),
        .result_o (alu_res),
        .carry_o  (alu_c),
        .zero_o   (alu_z)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imem_rd    = 1'b0;
        instr_done = 1'b0;
        ex_we      = 1'b0;
        rf_we      = 1'b0;
        flag_we    = 1'b0;
        rf_wdata   = alu_res_q;

        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start && armed_q) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                imem_rd = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d = imem_data;
                if (is_alu_op(dec_op)) begin
                    state_d = ST_EXEC;
                end else if (dec_op == OP_LOAD) begin
                    state_d = ST_WB;
                end else if (dec_op == OP_JMP) begin
                    pc_d       = imem_data[PROG_AW-1:0];
                    state_d    = ST_FETCH;
                    instr_done = 1'b1;
                end else if (dec_op == OP_HALT) begin
                    state_d    = ST_HALTED;
                    instr_done = 1'b1;
                end else begin
                    pc_d       = pc_q + PROG_AW'(1);
                    state_d    = ST_FETCH;
                    instr_done = 1'b1;
                end
            end
            ST_EXEC: begin
                ex_we   = 1'b1;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we      = 1'b1;
                instr_done = 1'b1;
                pc_d       = pc_q + PROG_AW'(1);
                state_d    = ST_FETCH;
                if (is_alu_op(ir_op)) begin
                    flag_we = 1'b1;
                end else begin
                    rf_wdata = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            alu_res_q <= '0;
            alu_c_q   <= 1'b0;
            alu_z_q   <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            armed_q <= 1'b1;
            if (ex_we) begin
                alu_res_q <= alu_res;
                alu_c_q   <= alu_c;
                alu_z_q   <= alu_z;
            end
            if (flag_we) begin
                z_q <= alu_z_q;
                c_q <= alu_c_q;
            end
        end
    end

    // NOTE: the register file is only four flops and must read as zero after
    // reset, so it is reset like any other state; a RAM macro would not be.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[ir_rd] <= rf_wdata;
        end
    end

    assign imem_addr = pc_q;
    assign dbg_data  = rf_q[dbg_addr];
    assign busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                       (state_q == ST_EXEC)  || (state_q == ST_WB);
    assign halted    = (state_q == ST_HALTED);
    assign flag_z    = z_q;
    assign flag_c    = c_q;

endmodule

// File: tb/tb_proc_seq_core.sv
// -----------------------------------------------------------------------------
// tb_proc_seq_core
//   Directed programs for proc_seq_core. The stimulus process loads the
//   program memory and pushes the hand-computed result of every instruction
//   into a queue; the monitor pops one entry per instr_done pulse and checks the
//   destination register, flags and the next fetch address one cycle later.
// -----------------------------------------------------------------------------
module tb_proc_seq_core;

    localparam int DATA_W  = 8;
    localparam int PROG_AW = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [PROG_AW-1:0] imem_addr;
    logic               imem_rd;
    logic [15:0]        imem_data = '0;
    logic [1:0]         dbg_addr = '0;
    logic [DATA_W-1:0]  dbg_data;
    logic               busy, halted, flag_z, flag_c, instr_done;

    logic [15:0]        mem [4];

    typedef struct {
        logic [1:0] sel;      // register to inspect after retirement
        logic [7:0] val;
        logic       z;
        logic       c;
        logic       is_halt;  // expect HALTED instead of a fetch
        logic [1:0] nxt;      // expected next fetch address
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   checked_cnt = 0;

    proc_seq_core #(.DATA_W(DATA_W), .PROG_AW(PROG_AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rd    (imem_rd),
        .imem_data  (imem_data),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data),
        .busy       (busy),
        .halted     (halted),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .instr_done (instr_done)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [7:0] val, input logic z,
                        input logic c, input logic is_halt, input logic [1:0] nxt);
        exp_t e;
        e.sel = sel; e.val = val; e.z = z; e.c = c; e.is_halt = is_halt; e.nxt = nxt;
        exp_q.push_back(e);
    endtask

    task automatic load_prog(input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
    endtask

    task automatic read_reg(input string name, input logic [1:0] sel, input logic [7:0] val);
        dbg_addr = sel;
        #1;
        check(name, dbg_data, val);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_retired(input string name, input int target);
        for (int i = 0; i < 200 && checked_cnt < target; i++) @(negedge clk);
        check(name, checked_cnt, target);
    endtask

    // Monitor: one scoreboard entry per retirement.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_done) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_retire: got retirement at imem_addr 0x%0h, expected none", imem_addr);
                end else begin
                    e = exp_q.pop_front();
                    @(posedge clk);
                    #1;
                    dbg_addr = e.sel;
                    #1;
                    check("retire_reg", dbg_data, e.val);
                    check("retire_flag_z", flag_z, e.z);
                    check("retire_flag_c", flag_c, e.c);
                    if (e.is_halt) begin
                        check("retire_halted", halted, 1'b1);
                    end else begin
                        check("retire_fetch_rd", imem_rd, 1'b1);
                        check("retire_fetch_addr", imem_addr, e.nxt);
                    end
                    checked_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        load_prog(16'h0000, 16'h0000, 16'h0000, 16'h0000);
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_flag_z", flag_z, 1'b0);
        check("rst_flag_c", flag_c, 1'b0);
        check("rst_imem_rd", imem_rd, 1'b0);
        check("rst_instr_done", instr_done, 1'b0);
        check("rst_imem_addr", imem_addr, 2'd0);
        for (int r = 0; r < 4; r++) read_reg("rst_reg", 2'(r), 8'h00);

        // start held across reset release is ignored.
        start = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("start_at_release_busy", busy, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // 1: LOAD R0,5; LOAD R1,3; ADD R2,R0,R1; HALT.
        load_prog(16'h8005, 16'h8103, 16'h0201, 16'hF000);
        push(2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd2);
        push(2'd2, 8'h08, 1'b0, 1'b0, 1'b0, 2'd3);
        push(2'd2, 8'h08, 1'b0, 1'b0, 1'b1, 2'd0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (!halted && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t1_halt_latency", n, 12);
        wait_retired("t1_retired", 4);
        check("t1_busy", busy, 1'b0);

        // 2: SUB R3,R1,R0 borrows; XOR R3,R3,R3 clears. Starts from HALTED.
        load_prog(16'h8005, 16'h8103, 16'h1310, 16'h4333);
        push(2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd2);
        push(2'd3, 8'hFE, 1'b0, 1'b1, 1'b0, 2'd3);
        push(2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
        pulse_start();
        wait_retired("t2_retired", 8);
        read_reg("t2_r2_intact", 2'd2, 8'h08);
        rst_n = 1'b0;
        #1;
        check("t2_rst_busy", busy, 1'b0);
        check("t2_rst_flag_z", flag_z, 1'b0);
        read_reg("t2_rst_r1", 2'd1, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 3: ADD R0,R0,R1 with 0xFF + 0x01 overwrites its own operand.
        load_prog(16'h80FF, 16'h8101, 16'h0001, 16'hF000);
        push(2'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd1, 8'h01, 1'b0, 1'b0, 1'b0, 2'd2);
        push(2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd3);
        push(2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 2'd0);
        pulse_start();
        wait_retired("t3_retired", 12);

        // 4a: all-NOP program from HALTED: fetch 0,1,2,3,0; regs and flags kept.
        load_prog(16'h7000, 16'h7000, 16'h7000, 16'h7000);
        push(2'd1, 8'h01, 1'b1, 1'b1, 1'b0, 2'd1);
        push(2'd1, 8'h01, 1'b1, 1'b1, 1'b0, 2'd2);
        push(2'd1, 8'h01, 1'b1, 1'b1, 1'b0, 2'd3);
        push(2'd1, 8'h01, 1'b1, 1'b1, 1'b0, 2'd0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("t4_first_fetch_rd", imem_rd, 1'b1);
        check("t4_first_fetch_addr", imem_addr, 2'd0);
        wait_retired("t4_retired", 16);
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4b: JMP 0x07 at addr 1 truncates to 3.
        load_prog(16'h7000, 16'hC007, 16'h7000, 16'hF000);
        push(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3);
        push(2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0);
        pulse_start();
        wait_retired("t4_jmp_retired", 19);

        // 5: reset during EXEC of ADD R2 aborts it.
        load_prog(16'h8005, 16'h8103, 16'h0201, 16'hF000);
        push(2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd2);
        pulse_start();
        wait_retired("t5_retired", 21);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t5_busy_in_exec", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_abort_busy", busy, 1'b0);
        read_reg("t5_abort_r0", 2'd0, 8'h00);
        read_reg("t5_abort_r2", 2'd2, 8'h00);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        read_reg("t5_post_r2", 2'd2, 8'h00);
        check("t5_post_busy", busy, 1'b0);
        check("t5_post_imem_rd", imem_rd, 1'b0);

        // 5/6: rerun, with a start pulse while busy that must be ignored.
        push(2'd0, 8'h05, 1'b0, 1'b0, 1'b0, 2'd1);
        push(2'd1, 8'h03, 1'b0, 1'b0, 1'b0, 2'd2);
        push(2'd2, 8'h08, 1'b0, 1'b0, 1'b0, 2'd3);
        push(2'd2, 8'h08, 1'b0, 1'b0, 1'b1, 2'd0);
        pulse_start();
        @(negedge clk);
        pulse_start();
        wait_retired("t6_retired", 25);
        check("t6_halted", halted, 1'b1);
        check("t6_queue_empty", exp_q.size(), 0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
